// File: rtl/fo_link_pkg.sv
// fo_link_pkg: constants shared across the fibre-link tx/rx byte path.
//   BYTE_W          - byte width on the tx byte channel
//   ST_READY/ST_ACK/ST_SELECT - byte scheduler state encoding
//   IDLE_BYTE       - value parked on tx_d when nothing has been granted yet
//   MODE_DATA/MODE_PRBS - tx_prbs_on levels
package fo_link_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_READY  = 2'd0;
  localparam logic [1:0] ST_ACK    = 2'd1;
  localparam logic [1:0] ST_SELECT = 2'd2;

  localparam logic [BYTE_W-1:0] IDLE_BYTE = 8'h00;

  localparam logic MODE_DATA = 1'b0;
  localparam logic MODE_PRBS = 1'b1;

endpackage

// File: rtl/tx_byte_sched_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick.
//   req_valid [N_REQ] - pending requests
//   ptr       [GW]    - highest-priority requester this round (< N_REQ)
//   hit               - at least one request pending
//   idx       [GW]    - first pending requester scanning ptr, ptr+1, ... mod N_REQ
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    ptr,
  output logic             hit,
  output logic [GW-1:0]    idx
);

  // w_cand[k] is the requester index sitting k places after ptr (wrapped)
  logic [GW-1:0] w_cand [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign w_cand[gi] = ((int'(ptr) + gi) >= N_REQ) ? GW'(int'(ptr) + gi - N_REQ)
                                                      : GW'(int'(ptr) + gi);
    end
  endgenerate

  // Scan from lowest priority upward so the nearest-to-ptr hit is written last
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_cand[k]]) begin
        hit = 1'b1;
        idx = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/tx_byte_sched.sv
// tx_byte_sched: byte scheduler in front of the tx serialiser (clk_bit domain).
// Round-robin shares the tx byte channel between N_REQ requesters, inserts an
// idle byte after MAX_RUN back-to-back data bytes, and switches PRBS mode on
// byte boundaries only.
//   clk_bit, rst     - bit clock, asynchronous active-high reset
//   byte_strobe      - tx samples tx_d/tx_d_valid/tx_prbs_on on this cycle
//   req_valid/req_data - per-requester pending flag and byte ([8i+7:8i])
//   req_ack          - pulse: requester i's byte was transmitted
//   prbs_req         - level request for PRBS test mode
//   tx_d/tx_d_valid/tx_prbs_on - byte, data-valid and PRBS mode to tx
//   grant_id         - owner of the presented byte
//   idle_forced      - pulse when a run-length idle is loaded
//   underrun         - pulse when byte_strobe arrives while not READY
module tx_byte_sched
  import fo_link_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_RUN = 16,
  parameter int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk_bit,
  input  logic                rst,
  input  logic                byte_strobe,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [8*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]    req_ack,
  input  logic                prbs_req,
  output logic [BYTE_W-1:0]   tx_d,
  output logic                tx_d_valid,
  output logic                tx_prbs_on,
  output logic [GW-1:0]       grant_id,
  output logic                idle_forced,
  output logic                underrun
);

  localparam int RUN_W = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

  logic [1:0]        r_state;
  logic [GW-1:0]     r_ptr;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [BYTE_W-1:0] r_tx_d;
  logic              r_tx_d_valid;
  logic              r_prbs_on;
  logic [GW-1:0]     r_grant_id;
  logic [N_REQ-1:0]  r_req_ack;
  logic              r_idle_forced;
  logic              r_underrun;

  logic              w_hit;
  logic [GW-1:0]     w_idx;
  logic [GW-1:0]     w_next_ptr;
  logic              w_force_idle;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .hit       (w_hit),
    .idx       (w_idx)
  );

  assign w_next_ptr   = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + GW'(1);
  assign w_force_idle = (MAX_RUN != 0) && (r_run_cnt == RUN_MAX);

  always_ff @(posedge clk_bit or posedge rst) begin
    if (rst) begin
      r_state       <= ST_SELECT;
      r_ptr         <= '0;
      r_run_cnt     <= '0;
      r_tx_d        <= IDLE_BYTE;
      r_tx_d_valid  <= 1'b0;
      r_prbs_on     <= MODE_DATA;
      r_grant_id    <= '0;
      r_req_ack     <= '0;
      r_idle_forced <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_req_ack     <= '0;
      r_idle_forced <= 1'b0;
      r_underrun    <= 1'b0;
      case (r_state)
        ST_READY: begin
          if (byte_strobe) begin
            r_state <= ST_ACK;
            if (r_tx_d_valid) begin
              // ack lands in the ACK cycle; the latched grant owns the byte
              r_req_ack <= N_REQ'(1) << r_grant_id;
              if (r_run_cnt != RUN_MAX) r_run_cnt <= r_run_cnt + RUN_W'(1);
            end else begin
              r_run_cnt <= '0;
            end
            // consumed byte must not be resampled by a too-early strobe
            r_tx_d_valid <= 1'b0;
          end
        end
        ST_ACK: begin
          r_state <= ST_SELECT;
          if (byte_strobe) r_underrun <= 1'b1;
        end
        default: begin
          r_state <= ST_READY;
          if (byte_strobe) r_underrun <= 1'b1;
          if (prbs_req) begin
            r_prbs_on    <= MODE_PRBS;
            r_tx_d_valid <= 1'b0;
            r_run_cnt    <= '0;
          end else begin
            r_prbs_on <= MODE_DATA;
            if (w_force_idle) begin
              r_tx_d_valid  <= 1'b0;
              r_idle_forced <= 1'b1;
              r_run_cnt     <= '0;
            end else if (w_hit) begin
              r_tx_d       <= req_data[BYTE_W*w_idx +: BYTE_W];
              r_tx_d_valid <= 1'b1;
              r_grant_id   <= w_idx;
              r_ptr        <= w_next_ptr;
            end else begin
              r_tx_d_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign tx_d        = r_tx_d;
  assign tx_d_valid  = r_tx_d_valid;
  assign tx_prbs_on  = r_prbs_on;
  assign grant_id    = r_grant_id;
  assign req_ack     = r_req_ack;
  assign idle_forced = r_idle_forced;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_tx_byte_sched.sv
module tb_tx_byte_sched;

  localparam int N_REQ   = 4;
  localparam int MAX_RUN = 4;
  localparam int GW      = 2;

  logic               clk_bit;
  logic               rst;
  logic               byte_strobe;
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic               prbs_req;
  logic [7:0]         tx_d;
  logic               tx_d_valid;
  logic               tx_prbs_on;
  logic [GW-1:0]      grant_id;
  logic               idle_forced;
  logic               underrun;

  tx_byte_sched #(
    .N_REQ   (N_REQ),
    .MAX_RUN (MAX_RUN),
    .GW      (GW)
  ) dut (
    .clk_bit     (clk_bit),
    .rst         (rst),
    .byte_strobe (byte_strobe),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .prbs_req    (prbs_req),
    .tx_d        (tx_d),
    .tx_d_valid  (tx_d_valid),
    .tx_prbs_on  (tx_prbs_on),
    .grant_id    (grant_id),
    .idle_forced (idle_forced),
    .underrun    (underrun)
  );

  initial clk_bit = 1'b0;
  always #5 clk_bit = ~clk_bit;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard of expected req_ack vectors, pushed at each strobe
  logic [N_REQ-1:0] ack_q [$];
  // bytes requester 3 still has to offer in the handshake phase
  logic [7:0] q3 [$];
  bit f_mode = 1'b0;

  // byte-level reference model
  int          m_ptr = 0;
  int          m_run = 0;
  bit          m_valid = 0;
  bit          m_prbs = 0;
  logic [7:0]  m_data = 8'h00;
  int          m_gid = 0;
  bit          m_forced = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_bit);
    #1;
  endtask

  task automatic m_reset();
    m_ptr = 0; m_run = 0; m_valid = 0; m_prbs = 0; m_data = 8'h00; m_gid = 0; m_forced = 0;
    ack_q.delete();
  endtask

  // what SELECT should load, given the inputs it sees now
  task automatic m_select();
    m_forced = 0;
    if (prbs_req) begin
      m_prbs = 1; m_valid = 0; m_run = 0;
    end else begin
      m_prbs = 0;
      if (MAX_RUN != 0 && m_run == MAX_RUN) begin
        m_valid = 0; m_forced = 1; m_run = 0;
      end else begin
        m_valid = 0;
        for (int k = 0; k < N_REQ; k++) begin
          int c;
          c = (m_ptr + k) % N_REQ;
          if (!m_valid && req_valid[c]) begin
            m_valid = 1;
            m_data  = req_data[8*c +: 8];
            m_gid   = c;
            m_ptr   = (c + 1) % N_REQ;
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_txd"}, 32'(tx_d), 32'h0);
    check({tag, "_valid"}, 32'(tx_d_valid), 32'h0);
    check({tag, "_prbs"}, 32'(tx_prbs_on), 32'h0);
    check({tag, "_gid"}, 32'(grant_id), 32'h0);
    check({tag, "_ack"}, 32'(req_ack), 32'h0);
    check({tag, "_forced"}, 32'(idle_forced), 32'h0);
    check({tag, "_underrun"}, 32'(underrun), 32'h0);
  endtask

  // One 8-cycle byte period; dbl holds the strobe for a second cycle.
  task automatic byte_slot(input bit dbl);
    logic [N_REQ-1:0] exp_ack;
    byte_strobe = 1'b1;
    check("prbs_on", 32'(tx_prbs_on), 32'(m_prbs));
    check("d_valid", 32'(tx_d_valid), 32'(m_valid));
    if (m_valid) begin
      check("tx_d", 32'(tx_d), 32'(m_data));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      $display("byte %02h from req %0d", m_data, m_gid);
    end else begin
      $display("byte idle (prbs=%0d)", m_prbs);
    end
    ack_q.push_back(m_valid ? (N_REQ'(1) << m_gid) : '0);
    if (m_valid) m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
    else m_run = 0;
    tick();
    byte_strobe = dbl;
    exp_ack = ack_q.pop_front();
    check("req_ack", 32'(req_ack), 32'(exp_ack));
    if (f_mode && req_ack[3]) begin
      if (q3.size() > 0) req_data[31:24] = q3.pop_front();
      else req_valid[3] = 1'b0;
    end
    tick();
    byte_strobe = 1'b0;
    check("ack_width", 32'(req_ack), 32'h0);
    check("underrun", 32'(underrun), 32'(dbl));
    m_select();
    tick();
    check("idle_forced", 32'(idle_forced), 32'(m_forced));
    check("underrun_clr", 32'(underrun), 32'h0);
    repeat (5) tick();
  endtask

  initial begin
    rst = 1'b1; byte_strobe = 1'b0; req_valid = '0; req_data = '0; prbs_req = 1'b0;
    #1;
    check_reset_outputs("rst0");
    repeat (3) tick();
    check_reset_outputs("rst1");
    m_reset();
    rst = 1'b0;
    m_select();
    tick();

    // no requests
    repeat (3) byte_slot(1'b0);

    // all four requesters, fixed bytes A0..A3
    req_valid = 4'hF;
    req_data  = 32'hA3A2A1A0;
    repeat (10) byte_slot(1'b0);

    // single requester 2 with 0x55: run limit inserts idles
    req_valid = 4'b0100;
    req_data  = 32'h0055_0000;
    repeat (11) byte_slot(1'b0);

    // PRBS entry mid-byte then exit, requester 1 pending
    req_valid = 4'b0010;
    req_data  = 32'h0000_7700;
    byte_slot(1'b0);
    repeat (3) tick();
    prbs_req = 1'b1;
    repeat (4) byte_slot(1'b0);
    prbs_req = 1'b0;
    repeat (3) byte_slot(1'b0);

    // early second strobe
    byte_slot(1'b1);
    repeat (2) byte_slot(1'b0);

    // requester 3 handshake 11,22,33
    req_valid = 4'b1000;
    req_data  = 32'h1100_0000;
    q3.push_back(8'h22);
    q3.push_back(8'h33);
    f_mode = 1'b1;
    repeat (6) byte_slot(1'b0);
    f_mode = 1'b0;

    // reset during ACK
    req_valid = 4'b1000;
    req_data  = 32'h4400_0000;
    repeat (2) byte_slot(1'b0);
    byte_strobe = 1'b1;
    check("pre_rst_valid", 32'(tx_d_valid), 32'(m_valid));
    tick();
    byte_strobe = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_ack");
    m_reset();
    repeat (2) tick();
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    m_select();
    tick();
    repeat (2) byte_slot(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
